// File: rtl/pll_seq_pkg.sv
// PLL reset sequencer shared package.
// Holds the sequencer state enum, default timing constants and width helpers.
package pll_seq_pkg;

    localparam int DEF_PLL_RST_CYCLES     = 16;
    localparam int DEF_LOCK_TIMEOUT       = 65536;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES        = 3;

    localparam int LLC_W = 8;

    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Bits needed to hold values 0 .. n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold values 0 .. n (at least 1 bit).
    function automatic int val_width(input int n);
        return (n > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with asynchronous active-high reset to 0.
// Ports: i_clk (dest clock), i_rst (async reset), i_d (async input), o_q (synced output).
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses PLL reset, waits for stable lock, then releases
// downstream reset; retries on lock timeout and latches FAULT after MAX_RETRIES.
// Ports: refclk (free-running ref clock), rst (async active-high reset),
//   pll_locked (async lock flag), pll_rst (PLL reset), sys_reset (downstream
//   reset), ready (in RUN), fault (in FAULT), lock_loss_count (saturating).
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             ready,
    output logic             fault,
    output logic [LLC_W-1:0] lock_loss_count
);

    localparam int CNT_W = cnt_width(
        max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES));
    localparam int RTY_W = val_width(MAX_RETRIES);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);
    localparam logic [LLC_W-1:0] LLC_MAX   = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [RTY_W-1:0] r_retries;
    logic [LLC_W-1:0] r_llc;
    logic             r_pll_rst;
    logic             r_sys_reset;
    logic             r_ready;
    logic             r_fault;

    logic             w_locked_s;
    state_t           w_nxt_state;
    logic [RTY_W-1:0] w_rty_inc;
    logic             w_timeout;
    logic             w_stable_done;
    logic             w_lock_lost;
    logic             w_counting;

    sync_2ff u_sync_locked (
        .i_clk (refclk),
        .i_rst (rst),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    assign w_rty_inc = r_retries + 1'b1;

    assign w_timeout = (r_state == S_WAIT_LOCK) && !w_locked_s
                    && (r_cnt == TO_LAST);

    assign w_stable_done = (r_state == S_STABLE) && w_locked_s
                        && (r_cnt == STB_LAST);

    assign w_lock_lost = (r_state == S_RUN) && !w_locked_s;

    // Only the three timed states advance the shared counter.
    assign w_counting = (r_state == S_PLL_RESET)
                     || (r_state == S_WAIT_LOCK)
                     || (r_state == S_STABLE);

    always_comb begin
        w_nxt_state = r_state;
        unique case (r_state)
            S_PLL_RESET: begin
                if (r_cnt == RST_LAST)
                    w_nxt_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (w_locked_s)
                    w_nxt_state = S_STABLE;
                else if (w_timeout)
                    w_nxt_state = (w_rty_inc == RTY_LIMIT) ? S_FAULT
                                                           : S_PLL_RESET;
            end
            S_STABLE: begin
                // A lock drop restarts qualification without a PLL reset.
                if (!w_locked_s)
                    w_nxt_state = S_WAIT_LOCK;
                else if (w_stable_done)
                    w_nxt_state = S_RUN;
            end
            S_RUN: begin
                if (!w_locked_s)
                    w_nxt_state = S_PLL_RESET;
            end
            S_FAULT: begin
                w_nxt_state = S_FAULT;
            end
            default: begin
                w_nxt_state = S_PLL_RESET;
            end
        endcase
    end

    // Outputs decode next state so they flip on the same edge as r_state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PLL_RESET;
            r_cnt       <= '0;
            r_retries   <= '0;
            r_llc       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_nxt_state;

            if (w_nxt_state != r_state)
                r_cnt <= '0;
            else if (w_counting)
                r_cnt <= r_cnt + 1'b1;

            if (w_timeout)
                r_retries <= w_rty_inc;
            else if (w_stable_done)
                r_retries <= '0;

            if (w_lock_lost && (r_llc != LLC_MAX))
                r_llc <= r_llc + 1'b1;

            r_pll_rst   <= (w_nxt_state == S_PLL_RESET)
                        || (w_nxt_state == S_FAULT);
            r_sys_reset <= (w_nxt_state != S_RUN);
            r_ready     <= (w_nxt_state == S_RUN);
            r_fault     <= (w_nxt_state == S_FAULT);
        end
    end

    assign pll_rst         = r_pll_rst;
    assign sys_reset       = r_sys_reset;
    assign ready           = r_ready;
    assign fault           = r_fault;
    assign lock_loss_count = r_llc;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: directed stimulus pushes expected
// output classes per cycle; a monitor pops and compares at each falling edge.
module tb_pll_reset_sequencer;

    localparam int P_RST = 4;
    localparam int P_TO  = 32;
    localparam int P_ST  = 8;
    localparam int P_MR  = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_count;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_TIMEOUT       (P_TO),
        .LOCK_STABLE_CYCLES (P_ST),
        .MAX_RETRIES        (P_MR)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .sys_reset       (sys_reset),
        .ready           (ready),
        .fault           (fault),
        .lock_loss_count (lock_loss_count)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    // Output classes: {pll_rst, sys_reset, ready, fault}
    typedef enum int { E_PR, E_WS, E_RUN, E_FLT } cls_t;

    typedef struct {
        int         cyc;
        logic [3:0] outs;
        int         llc;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    event ev_now;
    exp_t m_e;

    function automatic logic [3:0] cls_outs(input cls_t k);
        case (k)
            E_PR:    return 4'b1100;
            E_WS:    return 4'b0100;
            E_RUN:   return 4'b0010;
            default: return 4'b1101;
        endcase
    endfunction

    // c = -1 means "check right now" (fired through ev_now).
    task automatic expect_at(input int c, input cls_t k,
                             input int llc, input string nm);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.outs = cls_outs(k);
        e.llc  = llc;
        e.nm   = nm;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic at_neg(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    always @(negedge refclk or ev_now) begin
        while (sb.size() > 0 &&
               (sb[0].cyc == -1 ||
                (refclk == 1'b0 && sb[0].cyc <= cyc))) begin
            m_e = sb.pop_front();
            n_chk++;
            if (m_e.cyc != -1 && m_e.cyc < cyc) begin
                n_err++;
                $display("FAIL %s missed at cyc=%0d (now %0d)",
                         m_e.nm, m_e.cyc, cyc);
            end else if ({pll_rst, sys_reset, ready, fault} !== m_e.outs ||
                         (m_e.llc >= 0 &&
                          lock_loss_count !== 8'(m_e.llc))) begin
                n_err++;
                $display("FAIL %s cyc=%0d got pr/sr/rd/ft=%b llc=%0d want %b llc=%0d",
                         m_e.nm, cyc, {pll_rst, sys_reset, ready, fault},
                         lock_loss_count, m_e.outs, m_e.llc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int c0, f, k, c, e, p, w, w2, ex;

    initial begin
        // Async reset from power-up
        #1 rst = 1'b1;
        #1 expect_at(-1, E_PR, 0, "reset_async");
        ->ev_now;
        #1;
        repeat (3) @(negedge refclk);

        // Phase A: first lock
        rst = 1'b0;
        c0 = cyc;
        expect_at(c0 + 1, E_PR, 0, "a_prst1");
        expect_at(c0 + 3, E_PR, 0, "a_prst3");
        expect_at(c0 + 4, E_WS, 0, "a_prst_fall");
        f = c0 + 4;
        at_neg(f + 9);
        pll_locked = 1'b1;
        k = f + 10;
        expect_at(k + 9,  E_WS,  0, "a_ready_early");
        expect_at(k + 10, E_RUN, 0, "a_ready");
        at_neg(k + 12);

        // Phase B: loss in RUN, glitch during STABLE, recovery
        c = cyc;
        pll_locked = 1'b0;
        expect_at(c + 2, E_RUN, 0, "b_still_run");
        e = c + 3;
        expect_at(e,     E_PR, 1, "b_loss");
        expect_at(e + 3, E_PR, 1, "b_prst_end");
        at_neg(e + 4);
        pll_locked = 1'b1;
        for (int i = 4; i <= 21; i++)
            expect_at(e + i, E_WS, 1, "b_no_prst");
        expect_at(e + 22, E_RUN, 1, "b_ready_late");
        at_neg(e + 10);
        pll_locked = 1'b0;
        at_neg(e + 11);
        pll_locked = 1'b1;
        at_neg(e + 24);

        // Phase C: persistent loss -> retry -> FAULT
        c = cyc;
        pll_locked = 1'b0;
        p = c + 3;
        expect_at(p,      E_PR, 2, "c_loss");
        w = p + 4;
        expect_at(w,      E_WS, 2, "c_wait");
        expect_at(w + 31, E_WS, 2, "c_pre_to1");
        expect_at(w + 32, E_PR, 2, "c_retry1");
        expect_at(w + 35, E_PR, 2, "c_retry1_end");
        w2 = w + 36;
        expect_at(w2,      E_WS,  2, "c_wait2");
        expect_at(w2 + 31, E_WS,  2, "c_pre_to2");
        expect_at(w2 + 32, E_FLT, 2, "c_fault");
        for (int i = 10; i <= 120; i += 10)
            expect_at(w2 + 32 + i, E_FLT, 2, "c_fault_hold");
        at_neg(w2 + 32 + 122);

        // Phase D: rst out of FAULT, then rst mid-WAIT_LOCK
        @(posedge refclk);
        #2 rst = 1'b1;
        #1 expect_at(-1, E_PR, 0, "d_rst_from_fault");
        ->ev_now;
        #1;
        @(negedge refclk);
        rst = 1'b0;
        c0 = cyc;
        expect_at(c0 + 1, E_PR, 0, "d_prst1");
        expect_at(c0 + 3, E_PR, 0, "d_prst3");
        expect_at(c0 + 4, E_WS, 0, "d_wait");
        f = c0 + 4;
        at_neg(f + 10);
        @(posedge refclk);
        #2 rst = 1'b1;
        #1 expect_at(-1, E_PR, 0, "d_rst_mid_wait");
        ->ev_now;
        #1;
        @(negedge refclk);
        rst = 1'b0;
        c0 = cyc;
        expect_at(c0 + 3, E_PR, 0, "d2_prst3");
        expect_at(c0 + 4, E_WS, 0, "d2_wait");
        at_neg(c0 + 4);
        pll_locked = 1'b1;
        k = c0 + 5;
        expect_at(k + 10, E_RUN, 0, "d2_ready");
        at_neg(k + 10);

        // Phase E: 260 lock losses, counter saturates
        for (int n = 1; n <= 260; n++) begin
            c = cyc;
            ex = (n > 255) ? 255 : n;
            pll_locked = 1'b0;
            expect_at(c + 3,  E_PR,  ex, "e_loss");
            expect_at(c + 16, E_RUN, ex, "e_run");
            at_neg(c + 1);
            pll_locked = 1'b1;
            at_neg(c + 16);
        end

        at_neg(cyc + 3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The block SHALL have parameter PLL_RST_CYCLES, default 16: number of cycles pll_rst is held asserted per PLL reset pulse.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 65536: number of cycles to wait for lock before retrying.
REQ-003 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of cycles of continuous lock required before downstream release.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3: number of consecutive lock timeouts before permanent fault.
REQ-005 The block SHALL have port refclk, input, 1 bit: the single clock, the free-running PLL reference.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to refclk.
REQ-008 The block SHALL have port pll_rst, output, 1 bit: active-high reset driven to the PLL.
REQ-009 The block SHALL have port sys_reset, output, 1 bit: active-high reset for logic clocked by the PLL outputs.
REQ-010 The block SHALL have port ready, output, 1 bit: high only in RUN.
REQ-011 The block SHALL have port fault, output, 1 bit: high only in FAULT.
REQ-012 The block SHALL have port lock_loss_count, output, 8 bits: saturating count of lock losses seen in RUN.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer; locked_s denotes the synchronizer output, and all decisions SHALL use locked_s only.
REQ-014 The state machine SHALL have exactly the states PLL_RESET, WAIT_LOCK, STABLE, RUN and FAULT, with one shared cycle counter cleared on every state change.
REQ-015 In PLL_RESET, pll_rst SHALL be 1, and the machine SHALL go to WAIT_LOCK when counter = PLL_RST_CYCLES-1.
REQ-016 In WAIT_LOCK, pll_rst SHALL be 0, locked_s = 1 SHALL cause a move to STABLE, and reaching counter = LOCK_TIMEOUT-1 with locked_s = 0 SHALL increment retries.
REQ-017 On a WAIT_LOCK timeout, the machine SHALL go to FAULT if the incremented retries = MAX_RETRIES, otherwise to PLL_RESET.
REQ-018 In STABLE, locked_s = 0 SHALL cause a return to WAIT_LOCK without incrementing retries, and counter = LOCK_STABLE_CYCLES-1 with locked_s = 1 SHALL cause a move to RUN and clear retries.
REQ-019 In RUN, locked_s = 0 SHALL cause a move to PLL_RESET and a saturating increment of lock_loss_count (held at 255).
REQ-020 FAULT SHALL be terminal until rst, with pll_rst = 1, sys_reset = 1 and fault = 1.
REQ-021 sys_reset SHALL be 1 in every state except RUN, and ready SHALL equal (state == RUN).
REQ-022 All outputs SHALL be registered and decoded from next-state, so they change on the same edge as the state register.
REQ-023 Latency SHALL be fixed: pll_locked sampled high at edge k and held gives STABLE at edge k+2 and RUN/ready=1/sys_reset=0 at edge k+2+LOCK_STABLE_CYCLES.
REQ-024 Loss of lock SHALL be fixed at 3 edges: pll_locked sampled low at edge k in RUN gives sys_reset=1, ready=0 and pll_rst=1 at edge k+2.
REQ-025 The counter SHALL be wide enough for the largest of the three cycle parameters, and the retries register SHALL be $clog2(MAX_RETRIES+1) bits wide.

Reset
REQ-026 rst SHALL asynchronously force state PLL_RESET, counter 0, retries 0, synchronizer flops 0, pll_rst 1, sys_reset 1, ready 0, fault 0 and lock_loss_count 0.
REQ-027 rst asserted in any state, FAULT included, SHALL apply REQ-026 immediately without waiting for a refclk edge.
REQ-028 After rst deasserts, the sequence SHALL restart with a full PLL_RESET pulse.

Structure
REQ-029 Package pll_seq_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-030 Sub-module sync_2ff SHALL be a 1-bit, 2-flop synchronizer with asynchronous reset to 0, instantiated once for pll_locked.

Verification (bench params: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-031 The bench SHALL drive rst low, then pll_locked high 10 cycles after pll_rst falls, and check pll_rst high for exactly 4 cycles and ready=1/sys_reset=0 exactly 10 edges after the first sampling of locked.
REQ-032 The bench SHALL pulse pll_locked low for 1 cycle at STABLE counter 5 and check a return to WAIT_LOCK, no retry increment, and ready delayed accordingly, with no pll_rst pulse.
REQ-033 The bench SHALL hold pll_locked at 0 and check pll_rst re-pulses after 32 WAIT_LOCK cycles, then after the 2nd timeout fault=1 and pll_rst=1 held for 100+ cycles.
REQ-034 The bench SHALL drop pll_locked in RUN and check sys_reset=1 two edges later, lock_loss_count=1, a 4-cycle pll_rst pulse, and recovery to RUN when lock returns.
REQ-035 The bench SHALL assert rst mid-WAIT_LOCK between clock edges and check all outputs take their REQ-026 values before the next refclk edge.
REQ-036 The bench SHALL force 260 RUN lock losses and check lock_loss_count stays at 255.
